// File: rtl/writeback_regfile_pkg.sv
// Shared pipeline constants: default data/index widths and the hardwired zero-register index.
// Ports: none (package only); imported by the pipeline-register and writeback blocks.
// Kept separate so every pipeline stage agrees on the same widths and zero-register index.
package writeback_regfile_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned ZERO_REG_IDX   = 0;

  // Committed writes never target the zero register.
  function automatic logic is_commit(input logic we, input logic rst, input logic nonzero_idx);
    return we & nonzero_idx & ~rst;
  endfunction

endpackage

// File: rtl/regfile_array.sv
// Register storage array: 2**ADDR_WIDTH entries, one write port, two raw read ports.
// Ports: i_clock/i_reset (sync, active-high clear), i_we/i_waddr/i_wdata write port,
//        i_raddr1/i_raddr2 -> o_rdata1/o_rdata2 (combinational, no bypass, no zero-reg masking).
module regfile_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr1,
  input  logic [ADDR_WIDTH-1:0] i_raddr2,
  output logic [DATA_WIDTH-1:0] o_rdata1,
  output logic [DATA_WIDTH-1:0] o_rdata2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = r_mem[i_raddr1];
  assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage + register file: selects writeback data, commits it, serves two decode reads.
// Ports: clock/reset (sync active-high); regWrite/memToReg/readDataMemory/aluResult/writeRegister
//        from MEM/WB; readRegister1/2 -> readData1/2 (with write-before-read bypass); writeData; writeCount.
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  regWrite,
  input  logic                  memToReg,
  input  logic [DATA_WIDTH-1:0] readDataMemory,
  input  logic [DATA_WIDTH-1:0] aluResult,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2,
  output logic [DATA_WIDTH-1:0] writeData,
  output logic [31:0]           writeCount
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG_IDX);

  logic                  w_commit;
  logic [DATA_WIDTH-1:0] w_raw1;
  logic [DATA_WIDTH-1:0] w_raw2;
  logic [31:0]           r_write_count;

  // Writeback source select does not depend on regWrite; forwarding sees it every cycle.
  assign writeData = memToReg ? readDataMemory : aluResult;

  // Reset suppresses the commit, which also disables the bypass during reset.
  assign w_commit = is_commit(regWrite, reset, writeRegister != ZERO_IDX);

  regfile_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_we     (w_commit),
    .i_waddr  (writeRegister),
    .i_wdata  (writeData),
    .i_raddr1 (readRegister1),
    .i_raddr2 (readRegister2),
    .o_rdata1 (w_raw1),
    .o_rdata2 (w_raw2)
  );

  // Zero register masks first, then same-cycle bypass, then stored value.
  always_comb begin
    readData1 = w_raw1;
    if (readRegister1 == ZERO_IDX) begin
      readData1 = '0;
    end else if (w_commit && (readRegister1 == writeRegister)) begin
      readData1 = writeData;
    end
  end

  always_comb begin
    readData2 = w_raw2;
    if (readRegister2 == ZERO_IDX) begin
      readData2 = '0;
    end else if (w_commit && (readRegister2 == writeRegister)) begin
      readData2 = writeData;
    end
  end

  // Free-running 32-bit commit counter; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_write_count <= '0;
    end else if (w_commit) begin
      r_write_count <= r_write_count + 32'd1;
    end
  end

  assign writeCount = r_write_count;

endmodule
